spawn_scheduler: RTL
====================

// Module: spawn_scheduler
// PURPOSE
//  Consumes the 8-bit LFSR byte stream and turns it into timed, uniformly distributed obstacle-lane spawn events.
//  Sits directly downstream of the LFSR; drives its enable and reset, and hands lanes to game logic over valid/ready.
//  Also watches the RNG stream for a stuck value and restarts the LFSR when it sees one.
// PARAMETERS
//  LANES      5   number of lanes; legal lanes are 0..LANES-1 (2..8)
//  LANE_W     3   width of spawn_lane; 2**LANE_W >= LANES
//  MIN_GAP    16  minimum cycles between a spawn being taken and the next draw (8-bit)
//  GAP_SHIFT  2   random gap extension = rnd_in >> GAP_SHIFT
// PORTS
//  clock        in   1       system clock, all logic on posedge
//  reset        in   1       asynchronous, active-low; clears all state
//  start        in   1       game running; low forces IDLE
//  rnd_in       in   8       LFSR output byte
//  rng_enable   out  1       LFSR enable (LFSR holds 0x00 while low)
//  rng_reset    out  1       active-high, 1-cycle LFSR restart pulse
//  spawn_valid  out  1       spawn_lane holds a new lane
//  spawn_ready  in   1       consumer accepts the lane
//  spawn_lane   out  LANE_W  lane index
//  rng_stuck    out  1       sticky stuck-RNG flag
// BEHAVIOUR
//  Reset: state IDLE. spawn_valid, spawn_lane, rng_enable, rng_reset and rng_stuck all 0. Counters 0.
//  States:
//   IDLE
//    - rng_enable=0.
//    - When start=1: gap_cnt <= MIN_GAP + (rnd_in>>GAP_SHIFT), then go to WAIT.
//   WAIT
//    - gap_cnt decrements by 1 each cycle.
//    - In the cycle gap_cnt==0, go to DRAW; DRAW is entered MIN_GAP+1 cycles after the load when rnd_in=0.
//   DRAW
//    - Samples rnd_in once per cycle.
//    - On accept: register the lane and go to OFFER.
//   OFFER
//    - spawn_valid=1, spawn_lane stable.
//    - The cycle after a cycle with spawn_valid&&spawn_ready: spawn_valid=0 and the state is WAIT.
//    - The gap loaded on that same edge is MIN_GAP+(rnd_in>>GAP_SHIFT).
//  rng_enable = 1 in every state except IDLE, registered.
//  Gap sum uses 9-bit arithmetic and saturates at 255.
//  start=0 in any state: IDLE on the next edge.
//   - spawn_valid drops even mid-handshake (sole exception to valid-hold).
//   - rng_stuck clears.
//  Stuck detect (non-IDLE only, and not in the cycle after rng_reset):
//   - When rnd_in equals the previous sample on 2 consecutive compares (same value 3 cycles), rng_reset pulses for 1 cycle.
//   - rng_stuck sets and stays set.
//   - The compare history clears on that pulse.
//  spawn_ready while spawn_valid=0 is ignored.
// CONFIGURATION
//  REJECT_SAMPLE_EN defined: rejection sampling.
//   - cand = rnd_in[LANE_W-1:0]; accept when cand < LANES, otherwise stay in DRAW and retry next cycle.
//   - After 8 consecutive rejects, force lane 0 and accept.
//   - The reject counter clears on accept or IDLE.
//  REJECT_SAMPLE_EN undefined: scaled mapping.
//   - lane = (rnd_in*LANES)>>8; always accepted, DRAW lasts exactly 1 cycle.
// TESTING (LANES=5, MIN_GAP=16, GAP_SHIFT=2)
//  1. Reset low then release, start=1, real LFSR on rnd_in (0x00 at load):
//     rng_enable=1 the next cycle; DRAW is entered 17 cycles after the load; spawn_lane<5.
//  2. (REJECT) DRAW with rnd_in 0x07,0x06,0x05,0x03:
//     3 rejects; spawn_valid rises 4 cycles after DRAW entry with lane 3.
//  3. (REJECT) rnd_in alternating 0x0F/0x07 in DRAW:
//     lane 0 is forced after 8 rejects; no rng_reset.
//  4. spawn_ready=0 for 10 cycles in OFFER, then 1 with rnd_in=0x40:
//     valid and lane stable for all 10 cycles; valid=0 the next cycle; gap loaded = 32.
//  5. rnd_in held at 0x5A for 3 cycles in WAIT:
//     rng_reset high exactly 1 cycle; rng_stuck=1 until start=0.
//  6. start=0 during OFFER:
//     spawn_valid=0, rng_enable=0, state IDLE the next cycle.
//     Assert reset mid-WAIT: all outputs 0 immediately.
//     (scaled build) rnd_in=0x80 in DRAW -> lane 2.

Source files
------------

// File: rtl/spawn_scheduler_if.sv
// Spawn handshake between the scheduler (master) and the game logic consumer (slave).
interface spawn_scheduler_if #(
    parameter int LANE_W = 3
);
    logic              spawn_valid;
    logic              spawn_ready;
    logic [LANE_W-1:0] spawn_lane;

    modport master (output spawn_valid, output spawn_lane, input spawn_ready);
    modport slave  (input spawn_valid, input spawn_lane, output spawn_ready);
endinterface

// File: rtl/spawn_scheduler.sv
// Obstacle spawn scheduler: turns LFSR bytes into timed lane spawns and restarts a stuck LFSR.
// Build option: define REJECT_SAMPLE_EN for rejection-sampled lanes; default is scaled mapping.
module spawn_scheduler #(
    parameter int LANES     = 5,
    parameter int LANE_W    = 3,
    parameter int MIN_GAP   = 16,
    parameter int GAP_SHIFT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rnd_in,
    output logic              rng_enable,
    output logic              rng_reset,
    output logic              rng_stuck,
    spawn_scheduler_if.master spawn
);

    localparam logic [8:0] MIN_GAP_W = 9'(MIN_GAP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAW  = 2'd2,
        ST_OFFER = 2'd3
    } state_t;

    state_t            state_r;
    logic [7:0]        gap_r;
    logic [7:0]        prev_r;
    logic              hist_r;
    logic              match_r;
    logic              valid_r;
    logic [LANE_W-1:0] lane_r;

`ifdef REJECT_SAMPLE_EN
    localparam logic [7:0] LANES_B = 8'(LANES);
    logic [3:0]        rej_r;
`endif

    // Gap sum is computed 9 bits wide so large random extensions clamp instead of wrapping.
    function automatic logic [7:0] gap_load(input logic [7:0] rnd);
        logic [8:0] sum;
        sum = MIN_GAP_W + {1'b0, rnd >> GAP_SHIFT};
        return (sum > 9'd255) ? 8'd255 : sum[7:0];
    endfunction

`ifndef REJECT_SAMPLE_EN
    function automatic logic [LANE_W-1:0] scale_lane(input logic [7:0] rnd);
        return LANE_W'((16'(rnd) * 16'(LANES)) >> 8);
    endfunction
`endif

    assign spawn.spawn_valid = valid_r;
    assign spawn.spawn_lane  = lane_r;

    // Scheduler FSM, stuck-RNG watchdog and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            gap_r      <= 8'd0;
            prev_r     <= 8'd0;
            hist_r     <= 1'b0;
            match_r    <= 1'b0;
            valid_r    <= 1'b0;
            lane_r     <= '0;
            rng_enable <= 1'b0;
            rng_reset  <= 1'b0;
            rng_stuck  <= 1'b0;
`ifdef REJECT_SAMPLE_EN
            rej_r      <= 4'd0;
`endif
        end else if (!start) begin
            state_r    <= ST_IDLE;
            gap_r      <= 8'd0;
            hist_r     <= 1'b0;
            match_r    <= 1'b0;
            valid_r    <= 1'b0;
            rng_enable <= 1'b0;
            rng_reset  <= 1'b0;
            rng_stuck  <= 1'b0;
`ifdef REJECT_SAMPLE_EN
            rej_r      <= 4'd0;
`endif
        end else begin
            rng_enable <= 1'b1;
            rng_reset  <= 1'b0;

            // The LFSR is restarting during the cycle after a pulse, so that sample is not trusted.
            if ((state_r != ST_IDLE) && !rng_reset) begin
                prev_r <= rnd_in;
                hist_r <= 1'b1;
                if (hist_r && (rnd_in == prev_r)) begin
                    if (match_r) begin
                        rng_reset <= 1'b1;
                        rng_stuck <= 1'b1;
                        hist_r    <= 1'b0;
                        match_r   <= 1'b0;
                    end else begin
                        match_r   <= 1'b1;
                    end
                end else begin
                    match_r <= 1'b0;
                end
            end else begin
                match_r <= match_r;
            end

            case (state_r)
                ST_IDLE: begin
                    gap_r   <= gap_load(rnd_in);
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gap_r == 8'd0) begin
                        state_r <= ST_DRAW;
                    end else begin
                        gap_r   <= gap_r - 8'd1;
                    end
                end
                ST_DRAW: begin
`ifdef REJECT_SAMPLE_EN
                    if (8'(rnd_in[LANE_W-1:0]) < LANES_B) begin
                        lane_r  <= rnd_in[LANE_W-1:0];
                        valid_r <= 1'b1;
                        rej_r   <= 4'd0;
                        state_r <= ST_OFFER;
                    end else if (rej_r == 4'd7) begin
                        lane_r  <= '0;
                        valid_r <= 1'b1;
                        rej_r   <= 4'd0;
                        state_r <= ST_OFFER;
                    end else begin
                        rej_r   <= rej_r + 4'd1;
                    end
`else
                    lane_r  <= scale_lane(rnd_in);
                    valid_r <= 1'b1;
                    state_r <= ST_OFFER;
`endif
                end
                ST_OFFER: begin
                    if (spawn.spawn_ready) begin
                        valid_r <= 1'b0;
                        gap_r   <= gap_load(rnd_in);
                        state_r <= ST_WAIT;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
